// File: rtl/div_32_bit_seq.sv
// Restoring sequential divider for MIPS DIV/DIVU: one quotient bit per clock, LO=quotient, HI=remainder.
// Optional build macro DIV_EARLY_OUT_EN: skip the iterations when divisor is 0 or |dividend| < |divisor|.
module div_32_bit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] rem, quo, div_mag, dvd_raw;
    logic [CW-1:0]    count;
    logic             q_neg, r_neg, dz;
    logic             a_neg, b_neg, early;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    // MIN_INT stays 0x80..0, which is its correct unsigned magnitude
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

`ifdef DIV_EARLY_OUT_EN
    assign early = (divisor == '0) || (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // Shifted partial remainder can reach WIDTH+1 bits, so keep one extra guard bit for the borrow
    assign trial  = {1'b0, rem, quo[WIDTH-1]} - {2'b00, div_mag};
    assign borrow = trial[WIDTH+1];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = early ? FIX : RUN;
            RUN:     if (count == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem         <= '0;
            quo         <= '0;
            div_mag     <= '0;
            dvd_raw     <= '0;
            count       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    dvd_raw <= dividend;
                    div_mag <= b_mag;
                    q_neg   <= a_neg ^ b_neg;
                    r_neg   <= a_neg;
                    dz      <= (divisor == '0);
                    count   <= '0;
                    if (early) begin
                        rem <= a_mag;
                        quo <= '0;
                    end else begin
                        rem <= '0;
                        quo <= a_mag;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    quo   <= {quo[WIDTH-2:0], ~borrow};
                    rem   <= borrow ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= dvd_raw;
                    end else begin
                        quotient  <= q_neg ? -quo : quo;
                        remainder <= r_neg ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
